// File: rtl/unidad_mul_div_if.sv
// Request/response bundle between the register bank and the mul/div unit.
interface unidad_mul_div_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        wre_out;

    modport master (
        output start, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out, wre_out
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out, wre_out
    );
endinterface

// File: rtl/unidad_mul_div.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply or
// restoring divide on operand magnitudes, then a sign-fix cycle, then a
// one-cycle done/write pulse towards the register bank.
module unidad_mul_div (
    input  logic              CLK,
    input  logic              Reset_n,
    unidad_mul_div_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opa_mag_q, opa_mag_d;
    logic [31:0] opb_mag_q, opb_mag_d;
    logic [31:0] rem_q, rem_d;
    logic        neg_q, neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        wre_q, wre_d;
    logic [31:0] result_q, result_d;

    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] trial;
    logic [31:0] trial_sub;
    logic        q_bit;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wre_out = wre_q;
    assign bus.result  = result_q;
    assign bus.rd_out  = rd_q;

    // Next-state, datapath iteration and registered-output computation
    always_comb begin
        state_d   = state_q;
        f3_d      = f3_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_mag_d = opa_mag_q;
        opb_mag_d = opb_mag_q;
        rem_d     = rem_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        done_d    = 1'b0;
        wre_d     = 1'b0;

        a_signed  = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                    (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed  = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                    (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        a_neg     = a_signed && bus.op_a[31];
        b_neg     = b_signed && bus.op_b[31];
        a_mag     = a_neg ? (~bus.op_a + 32'd1) : bus.op_a;
        b_mag     = b_neg ? (~bus.op_b + 32'd1) : bus.op_b;

        mul_sum   = {1'b0, acc_q[63:32]} + (opb_mag_q[0] ? {1'b0, opa_mag_q} : '0);
        // Shifted partial remainder with the next dividend bit appended
        trial     = {rem_q, acc_q[31]};
        trial_sub = trial[31:0] - opb_mag_q;
        q_bit     = (trial >= {1'b0, opb_mag_q});

        prod_fix  = neg_q ? (~acc_q + 64'd1) : acc_q;
        quo_fix   = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix   = rem_neg_q ? (~rem_q + 32'd1) : rem_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    f3_d      = bus.funct3;
                    rd_d      = bus.rd_in;
                    cnt_d     = '0;
                    rem_d     = '0;
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    opa_mag_d = a_mag;
                    opb_mag_d = b_mag;
                    acc_d     = bus.funct3[2] ? {32'd0, a_mag} : '0;
                    if (bus.funct3[2] && (bus.op_b == '0)) begin
                        result_d = bus.funct3[1] ? bus.op_a : '1;
                        done_d   = 1'b1;
                        wre_d    = (bus.rd_in != '0);
                        state_d  = DONE;
                    end else if (bus.funct3[2] && !bus.funct3[0] &&
                                 (bus.op_a == 32'h8000_0000) && (bus.op_b == '1)) begin
                        result_d = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
                        done_d   = 1'b1;
                        wre_d    = (bus.rd_in != '0);
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (!f3_q[2]) begin
                    acc_d     = {mul_sum, acc_q[31:1]};
                    opb_mag_d = opb_mag_q >> 1;
                end else begin
                    rem_d = q_bit ? trial_sub : trial[31:0];
                    acc_d = {acc_q[63:32], acc_q[30:0], q_bit};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                case (f3_q)
                    3'b000:                 result_d = prod_fix[31:0];
                    3'b001, 3'b010, 3'b011: result_d = prod_fix[63:32];
                    3'b100, 3'b101:         result_d = quo_fix;
                    default:                result_d = rem_fix;
                endcase
                done_d  = 1'b1;
                wre_d   = (rd_q != '0);
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            f3_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_mag_q <= '0;
            opb_mag_q <= '0;
            rem_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wre_q     <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            f3_q      <= f3_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_mag_q <= opa_mag_d;
            opb_mag_q <= opb_mag_d;
            rem_q     <= rem_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wre_q     <= wre_d;
            result_q  <= result_d;
        end
    end
endmodule

// File: tb/tb_unidad_mul_div.sv
// Directed-vector bench for unidad_mul_div.
module tb_unidad_mul_div;
    logic clk = 1'b0;
    logic Reset_n;
    int   total = 0;
    int   bad   = 0;

    unidad_mul_div_if bus ();

    unidad_mul_div dut (
        .CLK     (clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Issue one request (accepted at edge 0) and wait up to 60 cycles for done.
    // Returns in the done cycle (1 ns after its starting edge); lat=0 on timeout.
    task automatic issue_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, output int lat, output logic [31:0] res,
                            output logic [4:0] rdo, output logic wre);
        int cyc;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op_a = 32'h1234_5678; bus.op_b = 32'h9abc_def0; bus.rd_in = 5'd17;
        lat = 0; res = 'x; rdo = 'x; wre = 1'bx;
        cyc = 1;
        while (cyc <= 60) begin
            if (bus.done === 1'b1) begin
                lat = cyc; res = bus.result; rdo = bus.rd_out; wre = bus.wre_out;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        bus.start = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.busy, bus.done, bus.wre_out} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.wre_out});
        end
        total++;
        if (bus.result !== 32'd0 || bus.rd_out !== 5'd0) begin
            bad++; $display("FAIL reset_data got result=%h rd=%0d want 0/0", bus.result, bus.rd_out);
        end
        Reset_n = 1'b1;
        // Reset asserted together with start: request must be dropped
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd4; bus.rd_in = 5'd1;
        Reset_n = 1'b0;
        @(posedge clk); #1;
        Reset_n = 1'b1; bus.start = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_vs_start got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_mul();
        int lat; logic [31:0] res; logic [4:0] rdo; logic wre;
        issue_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, res, rdo, wre);
        total++;
        if (lat !== 34) begin bad++; $display("FAIL mul_latency got %0d want 34", lat); end
        total++;
        if (res !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_result got %h want ffffffeb", res); end
        total++;
        if (rdo !== 5'd5 || wre !== 1'b1) begin
            bad++; $display("FAIL mul_write got rd=%0d wre=%b want 5/1", rdo, wre);
        end
        @(posedge clk); #1;
        total++;
        if ({bus.done, bus.wre_out, bus.busy} !== 3'b000) begin
            bad++; $display("FAIL mul_pulse_end got done/wre/busy=%b want 000", {bus.done, bus.wre_out, bus.busy});
        end
    endtask

    task automatic test_mulh();
        int lat; logic [31:0] res; logic [4:0] rdo; logic wre;
        issue_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, lat, res, rdo, wre);
        total++;
        if (res !== 32'h4000_0000 || lat !== 34) begin
            bad++; $display("FAIL mulh got %h lat=%0d want 40000000 lat=34", res, lat);
        end
        issue_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, lat, res, rdo, wre);
        total++;
        if (res !== 32'hFFFF_FFFE || lat !== 34) begin
            bad++; $display("FAIL mulhu got %h lat=%0d want fffffffe lat=34", res, lat);
        end
        issue_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, lat, res, rdo, wre);
        total++;
        if (res !== 32'hFFFF_FFFF || lat !== 34) begin
            bad++; $display("FAIL mulhsu got %h lat=%0d want ffffffff lat=34", res, lat);
        end
    endtask

    task automatic test_div();
        int lat; logic [31:0] res; logic [4:0] rdo; logic wre;
        issue_op(3'b101, 32'd100, 32'd7, 5'd4, lat, res, rdo, wre);
        total++;
        if (res !== 32'd14 || lat !== 34) begin bad++; $display("FAIL divu got %h lat=%0d want 0000000e lat=34", res, lat); end
        issue_op(3'b111, 32'd100, 32'd7, 5'd4, lat, res, rdo, wre);
        total++;
        if (res !== 32'd2 || lat !== 34) begin bad++; $display("FAIL remu got %h lat=%0d want 00000002 lat=34", res, lat); end
        issue_op(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd4, lat, res, rdo, wre);
        total++;
        if (res !== 32'hFFFF_FFF2 || lat !== 34) begin bad++; $display("FAIL div_neg got %h lat=%0d want fffffff2 lat=34", res, lat); end
        issue_op(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd4, lat, res, rdo, wre);
        total++;
        if (res !== 32'hFFFF_FFFE || lat !== 34) begin bad++; $display("FAIL rem_neg got %h lat=%0d want fffffffe lat=34", res, lat); end
    endtask

    task automatic test_special();
        int lat; logic [31:0] res; logic [4:0] rdo; logic wre;
        issue_op(3'b100, 32'd5, 32'd0, 5'd6, lat, res, rdo, wre);
        total++;
        if (res !== 32'hFFFF_FFFF || lat !== 1 || wre !== 1'b1) begin
            bad++; $display("FAIL div_by_zero got %h lat=%0d wre=%b want ffffffff lat=1 wre=1", res, lat, wre);
        end
        @(posedge clk); #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL special_idle got busy=%b done=%b want 0/0", bus.busy, bus.done);
        end
        issue_op(3'b111, 32'd5, 32'd0, 5'd6, lat, res, rdo, wre);
        total++;
        if (res !== 32'd5 || lat !== 1) begin bad++; $display("FAIL remu_by_zero got %h lat=%0d want 00000005 lat=1", res, lat); end
        issue_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, lat, res, rdo, wre);
        total++;
        if (res !== 32'h8000_0000 || lat !== 1) begin bad++; $display("FAIL div_ovf got %h lat=%0d want 80000000 lat=1", res, lat); end
        issue_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, lat, res, rdo, wre);
        total++;
        if (res !== 32'd0 || lat !== 1) begin bad++; $display("FAIL rem_ovf got %h lat=%0d want 00000000 lat=1", res, lat); end
    endtask

    task automatic test_start_ignored();
        int dones = 0; int first = 0; logic [31:0] res = '0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd4; bus.rd_in = 5'd1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.funct3 = 3'b101; bus.op_a = 32'd1; bus.op_b = 32'd1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (bus.done === 1'b1) begin
                dones++;
                if (first == 0) begin first = cyc; res = bus.result; end
            end
            if (cyc == 35) begin
                total++;
                if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignored_start_busy got %b want 0", bus.busy); end
            end
            bus.start = (cyc == 10 || cyc == 34);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        total++;
        if (dones !== 1 || first !== 34 || res !== 32'd12) begin
            bad++; $display("FAIL ignored_start got dones=%0d at=%0d res=%h want 1/34/0000000c", dones, first, res);
        end
    endtask

    task automatic test_rd_zero();
        int lat; logic [31:0] res; logic [4:0] rdo; logic wre;
        issue_op(3'b000, 32'd2, 32'd3, 5'd0, lat, res, rdo, wre);
        total++;
        if (lat !== 34 || res !== 32'd6 || rdo !== 5'd0 || wre !== 1'b0) begin
            bad++; $display("FAIL rd_zero got lat=%0d res=%h rd=%0d wre=%b want 34/00000006/0/0", lat, res, rdo, wre);
        end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd100; bus.op_b = 32'd7; bus.rd_in = 5'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        Reset_n = 1'b0;
        @(posedge clk); #1;
        Reset_n = 1'b1;
        total++;
        if ({bus.busy, bus.done, bus.wre_out} !== 3'b000 || bus.result !== 32'd0 || bus.rd_out !== 5'd0) begin
            bad++; $display("FAIL abort_outputs got flags=%b result=%h rd=%0d want 000/0/0",
                            {bus.busy, bus.done, bus.wre_out}, bus.result, bus.rd_out);
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL abort_no_done got %0d dones want 0", dones); end
    endtask

    task automatic test_after_reset();
        int lat; logic [31:0] res; logic [4:0] rdo; logic wre;
        issue_op(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd9, lat, res, rdo, wre);
        total++;
        if (lat !== 34 || res !== 32'hFFFF_FFF2 || rdo !== 5'd9 || wre !== 1'b1) begin
            bad++; $display("FAIL after_reset got lat=%0d res=%h rd=%0d wre=%b want 34/fffffff2/9/1", lat, res, rdo, wre);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res; logic [4:0] rdo; logic wre;
        issue_op(3'b000, 32'd10, 32'd10, 5'd8, lat, res, rdo, wre);
        issue_op(3'b101, 32'd81, 32'd9, 5'd8, lat, res, rdo, wre);
        total++;
        if (lat !== 34 || res !== 32'd9) begin
            bad++; $display("FAIL back_to_back got lat=%0d res=%h want 34/00000009", lat, res);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_start_ignored();
        test_rd_zero();
        test_reset_abort();
        test_after_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
